// File: rtl/tlc_phase_monitor.sv
// Receive-side safety monitor for the two-road traffic-light lamps: decodes phases, times dwell, flags errors.
// Optional build macro TLC_MON_CYCLE_COUNT_EN adds the CYCLES output counting completed FY->HG cycles.
module tlc_phase_monitor #(
  parameter int unsigned MIN_GREEN  = 4,
  parameter int unsigned MIN_YELLOW = 2,
  parameter int unsigned MAX_YELLOW = 8,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             EN,
  input  logic [2:0]       HL,
  input  logic [2:0]       FL,
  output logic [1:0]       PHASE,
  output logic             SYNCED,
  output logic [CNT_W-1:0] DWELL,
  output logic             PHASE_CHG,
  output logic             ERR,
  output logic [2:0]       ERR_CODE
`ifdef TLC_MON_CYCLE_COUNT_EN
  ,
  output logic [15:0]      CYCLES
`endif
);

  localparam logic [1:0] PH_HG = 2'd0;
  localparam logic [1:0] PH_FY = 2'd3;

  localparam logic [2:0] C_NONE    = 3'd0;
  localparam logic [2:0] C_ILLEGAL = 3'd1;
  localparam logic [2:0] C_ORDER   = 3'd2;
  localparam logic [2:0] C_SHORT_G = 3'd3;
  localparam logic [2:0] C_SHORT_Y = 3'd4;
  localparam logic [2:0] C_LONG_Y  = 3'd5;

  typedef enum logic {S_SYNC, S_LOCKED} state_t;

  state_t           r_state;
  logic [2:0]       r_hl_q;
  logic [2:0]       r_fl_q;
  logic [1:0]       r_phase;
  logic [CNT_W-1:0] r_dwell;
  logic             r_chg;
  logic             r_err;
  logic [2:0]       r_err_code;
`ifdef TLC_MON_CYCLE_COUNT_EN
  logic [15:0]      r_cycles;
`endif

  logic             w_legal;
  logic [1:0]       w_p;
  logic [1:0]       w_succ;
  logic [2:0]       w_code;
  logic [CNT_W-1:0] w_dwell_inc;

  // Lamp pattern decode of the registered pins.
  always_comb begin
    w_legal = 1'b1;
    w_p     = 2'd0;
    case ({r_hl_q, r_fl_q})
      6'b001_100: w_p = 2'd0;
      6'b010_100: w_p = 2'd1;
      6'b100_001: w_p = 2'd2;
      6'b100_010: w_p = 2'd3;
      default:    w_legal = 1'b0;
    endcase
  end

  assign w_succ      = r_phase + 2'd1;
  assign w_dwell_inc = (r_dwell == {CNT_W{1'b1}}) ? r_dwell : r_dwell + CNT_W'(1);

  // At most one condition applies per edge; odd phases are the yellows.
  always_comb begin
    w_code = C_NONE;
    if (r_state == S_LOCKED) begin
      if (!w_legal) begin
        w_code = C_ILLEGAL;
      end else if (w_p == r_phase) begin
        if (r_phase[0] && (r_dwell == CNT_W'(MAX_YELLOW))) w_code = C_LONG_Y;
      end else if (w_p == w_succ) begin
        if (!r_phase[0] && (r_dwell < CNT_W'(MIN_GREEN)))     w_code = C_SHORT_G;
        else if (r_phase[0] && (r_dwell < CNT_W'(MIN_YELLOW))) w_code = C_SHORT_Y;
      end else begin
        w_code = C_ORDER;
      end
    end
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      r_state    <= S_SYNC;
      r_hl_q     <= 3'd0;
      r_fl_q     <= 3'd0;
      r_phase    <= 2'd0;
      r_dwell    <= '0;
      r_chg      <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 3'd0;
`ifdef TLC_MON_CYCLE_COUNT_EN
      r_cycles   <= 16'd0;
`endif
    end else if (EN) begin
      r_hl_q <= HL;
      r_fl_q <= FL;
      r_chg  <= 1'b0;
      if ((w_code != C_NONE) && !r_err) begin
        r_err      <= 1'b1;
        r_err_code <= w_code;
      end
      case (r_state)
        S_SYNC: begin
          if (w_legal) begin
            r_state <= S_LOCKED;
            r_phase <= w_p;
            r_dwell <= CNT_W'(1);
          end
        end
        S_LOCKED: begin
          if (!w_legal) begin
            r_state <= S_SYNC;
            r_dwell <= '0;
          end else if (w_p == r_phase) begin
            r_dwell <= w_dwell_inc;
          end else begin
            r_phase <= w_p;
            r_dwell <= CNT_W'(1);
            r_chg   <= 1'b1;
`ifdef TLC_MON_CYCLE_COUNT_EN
            // FY->HG is always the in-order successor, never a resync.
            if ((r_phase == PH_FY) && (w_p == PH_HG)) r_cycles <= r_cycles + 16'd1;
`endif
          end
        end
        default: r_state <= S_SYNC;
      endcase
    end else begin
      r_chg <= 1'b0;
    end
  end

  assign PHASE     = r_phase;
  assign SYNCED    = (r_state == S_LOCKED);
  assign DWELL     = r_dwell;
  assign PHASE_CHG = r_chg;
  assign ERR       = r_err;
  assign ERR_CODE  = r_err_code;
`ifdef TLC_MON_CYCLE_COUNT_EN
  assign CYCLES    = r_cycles;
`endif

endmodule

// File: tb/tb_tlc_phase_monitor.sv
// Directed bench for tlc_phase_monitor: reference model feeds a scoreboard queue, plus hand-derived checkpoints.
module tb_tlc_phase_monitor;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned MIN_G = 4;
  localparam int unsigned MIN_Y = 2;
  localparam int unsigned MAX_Y = 8;

  localparam logic [5:0] P_HG  = 6'b001_100;
  localparam logic [5:0] P_HY  = 6'b010_100;
  localparam logic [5:0] P_FG  = 6'b100_001;
  localparam logic [5:0] P_FY  = 6'b100_010;
  localparam logic [5:0] P_BAD = 6'b011_100;

  logic             CK = 1'b0;
  logic             RST;
  logic             EN;
  logic [2:0]       HL;
  logic [2:0]       FL;
  logic [1:0]       PHASE;
  logic             SYNCED;
  logic [CNT_W-1:0] DWELL;
  logic             PHASE_CHG;
  logic             ERR;
  logic [2:0]       ERR_CODE;
`ifdef TLC_MON_CYCLE_COUNT_EN
  logic [15:0]      CYCLES;
`endif

  always #5 CK = ~CK;

  tlc_phase_monitor #(
    .MIN_GREEN (MIN_G),
    .MIN_YELLOW(MIN_Y),
    .MAX_YELLOW(MAX_Y),
    .CNT_W     (CNT_W)
  ) dut (
    .CK       (CK),
    .RST      (RST),
    .EN       (EN),
    .HL       (HL),
    .FL       (FL),
    .PHASE    (PHASE),
    .SYNCED   (SYNCED),
    .DWELL    (DWELL),
    .PHASE_CHG(PHASE_CHG),
    .ERR      (ERR),
    .ERR_CODE (ERR_CODE)
`ifdef TLC_MON_CYCLE_COUNT_EN
    ,
    .CYCLES   (CYCLES)
`endif
  );

  typedef struct {
    logic [1:0]       phase;
    logic             synced;
    logic [CNT_W-1:0] dwell;
    logic             chg;
    logic             err;
    logic [2:0]       code;
    logic [15:0]      cycles;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   chg_count = 0;

  // Reference model state
  logic [2:0]       m_hlq, m_flq;
  logic [1:0]       m_phase;
  logic             m_synced;
  logic [CNT_W-1:0] m_dwell;
  logic             m_chg, m_err;
  logic [2:0]       m_code;
  logic [15:0]      m_cycles;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] m_decode(input logic [2:0] h, input logic [2:0] f);
    if (h == 3'b001 && f == 3'b100) return 3'b100;
    if (h == 3'b010 && f == 3'b100) return 3'b101;
    if (h == 3'b100 && f == 3'b001) return 3'b110;
    if (h == 3'b100 && f == 3'b010) return 3'b111;
    return 3'b000;
  endfunction

  task automatic model_reset();
    m_hlq = 3'd0; m_flq = 3'd0; m_phase = 2'd0; m_synced = 1'b0; m_dwell = '0;
    m_chg = 1'b0; m_err = 1'b0; m_code = 3'd0; m_cycles = 16'd0;
  endtask

  task automatic model_step(input logic [2:0] hl, input logic [2:0] fl, input logic en);
    logic [2:0] d;
    logic [1:0] p;
    logic [2:0] c;
    if (!en) begin
      m_chg = 1'b0;
      return;
    end
    d = m_decode(m_hlq, m_flq);
    p = d[1:0];
    c = 3'd0;
    m_chg = 1'b0;
    if (!m_synced) begin
      if (d[2]) begin m_phase = p; m_dwell = 1; m_synced = 1'b1; end
    end else if (!d[2]) begin
      c = 3'd1; m_synced = 1'b0; m_dwell = '0;
    end else if (p == m_phase) begin
      if ((m_phase == 2'd1 || m_phase == 2'd3) && m_dwell == CNT_W'(MAX_Y)) c = 3'd5;
      if (m_dwell != '1) m_dwell = m_dwell + 1;
    end else if (p == 2'(m_phase + 2'd1)) begin
      if ((m_phase == 2'd0 || m_phase == 2'd2) && m_dwell < CNT_W'(MIN_G)) c = 3'd3;
      if ((m_phase == 2'd1 || m_phase == 2'd3) && m_dwell < CNT_W'(MIN_Y)) c = 3'd4;
      if (m_phase == 2'd3) m_cycles = m_cycles + 16'd1;
      m_phase = p; m_dwell = 1; m_chg = 1'b1;
    end else begin
      c = 3'd2; m_phase = p; m_dwell = 1; m_chg = 1'b1;
    end
    if (c != 3'd0 && !m_err) begin m_err = 1'b1; m_code = c; end
    m_hlq = hl;
    m_flq = fl;
  endtask

  // Drive one cycle, push the model's expectation, then pop and compare after the edge.
  task automatic cyc(input logic [2:0] hl, input logic [2:0] fl, input logic en);
    exp_t e;
    HL = hl; FL = fl; EN = en;
    model_step(hl, fl, en);
    e.phase = m_phase; e.synced = m_synced; e.dwell = m_dwell; e.chg = m_chg;
    e.err = m_err; e.code = m_code; e.cycles = m_cycles;
    sb_q.push_back(e);
    @(posedge CK);
    #1;
    e = sb_q.pop_front();
    if (PHASE_CHG === 1'b1) chg_count++;
    check("sb_phase",  32'(PHASE),     32'(e.phase));
    check("sb_synced", 32'(SYNCED),    32'(e.synced));
    check("sb_dwell",  32'(DWELL),     32'(e.dwell));
    check("sb_chg",    32'(PHASE_CHG), 32'(e.chg));
    check("sb_err",    32'(ERR),       32'(e.err));
    check("sb_code",   32'(ERR_CODE),  32'(e.code));
`ifdef TLC_MON_CYCLE_COUNT_EN
    check("sb_cycles", 32'(CYCLES),    32'(e.cycles));
`endif
  endtask

  task automatic hold(input logic [5:0] pat, input int n);
    for (int i = 0; i < n; i++) cyc(pat[5:3], pat[2:0], 1'b1);
  endtask

  task automatic do_reset();
    RST = 1'b1; EN = 1'b1; HL = 3'd0; FL = 3'd0;
    model_reset();
    chg_count = 0;
    #1;
    check("rst_phase",  32'(PHASE),     32'd0);
    check("rst_synced", 32'(SYNCED),    32'd0);
    check("rst_dwell",  32'(DWELL),     32'd0);
    check("rst_chg",    32'(PHASE_CHG), 32'd0);
    check("rst_err",    32'(ERR),       32'd0);
    check("rst_code",   32'(ERR_CODE),  32'd0);
`ifdef TLC_MON_CYCLE_COUNT_EN
    check("rst_cycles", 32'(CYCLES),    32'd0);
`endif
    @(posedge CK);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b0; EN = 1'b1; HL = 3'd0; FL = 3'd0;
    model_reset();
    #2;

    // Legal full cycle with minimum dwells.
    do_reset();
    hold(P_HG, 4);
    hold(P_HY, 1);
    check("t1_dwell_pre_chg", 32'(DWELL), 32'd4);
    check("t1_phase_pre_chg", 32'(PHASE), 32'd0);
    hold(P_HY, 1);
    check("t1_phase_hy", 32'(PHASE), 32'd1);
    check("t1_chg_hy",   32'(PHASE_CHG), 32'd1);
    hold(P_FG, 4);
    hold(P_FY, 2);
    hold(P_HG, 2);
    check("t1_phase_end", 32'(PHASE), 32'd0);
    check("t1_err",       32'(ERR),   32'd0);
    check("t1_chg_count", 32'(chg_count), 32'd4);

    // Short green.
    do_reset();
    hold(P_HG, 3);
    hold(P_HY, 2);
    check("t2_err",   32'(ERR),      32'd1);
    check("t2_code",  32'(ERR_CODE), 32'd3);
    check("t2_phase", 32'(PHASE),    32'd1);

    // Yellow over-length, then a later order error must not overwrite the code.
    do_reset();
    hold(P_HG, 4);
    hold(P_HY, 9);
    check("t3_dwell_8",  32'(DWELL), 32'd8);
    check("t3_err_pre",  32'(ERR),   32'd0);
    hold(P_HY, 1);
    check("t3_err",      32'(ERR),      32'd1);
    check("t3_code",     32'(ERR_CODE), 32'd5);
    check("t3_dwell_9",  32'(DWELL),    32'd9);
    hold(P_HG, 2);
    hold(P_FG, 2);
    check("t3_code_kept", 32'(ERR_CODE), 32'd5);
    check("t3_phase_fg",  32'(PHASE),    32'd2);

    // Illegal pattern drops lock; next legal pattern relocks silently.
    do_reset();
    hold(P_HG, 3);
    hold(P_BAD, 1);
    hold(P_FG, 1);
    check("t4_code",   32'(ERR_CODE), 32'd1);
    check("t4_synced", 32'(SYNCED),   32'd0);
    check("t4_dwell0", 32'(DWELL),    32'd0);
    hold(P_FG, 1);
    check("t4_phase",   32'(PHASE),     32'd2);
    check("t4_dwell1",  32'(DWELL),     32'd1);
    check("t4_relock",  32'(SYNCED),    32'd1);
    check("t4_chg",     32'(PHASE_CHG), 32'd0);
    check("t4_code_kept", 32'(ERR_CODE), 32'd1);

    // Asynchronous reset mid-cycle while locked in HY.
    do_reset();
    hold(P_HG, 4);
    hold(P_HY, 2);
    check("t5_phase_hy", 32'(PHASE), 32'd1);
    check("t5_dwell_1",  32'(DWELL), 32'd1);
    #2;
    do_reset();
    hold(P_FG, 6);
    check("t5_phase_fg", 32'(PHASE),  32'd2);
    check("t5_dwell_5",  32'(DWELL),  32'd5);
    check("t5_synced",   32'(SYNCED), 32'd1);
    check("t5_err",      32'(ERR),    32'd0);

    // Three full cycles, then an enable freeze mid-HG.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      hold(P_HG, 4);
      hold(P_HY, 2);
      hold(P_FG, 4);
      hold(P_FY, 2);
    end
    hold(P_HG, 4);
    check("t6_err",   32'(ERR),   32'd0);
    check("t6_dwell", 32'(DWELL), 32'd3);
`ifdef TLC_MON_CYCLE_COUNT_EN
    check("t6_cycles", 32'(CYCLES), 32'd3);
`endif
    for (int k = 0; k < 10; k++) cyc(P_FY[5:3], P_FY[2:0], 1'b0);
    check("t6_dwell_frozen", 32'(DWELL),     32'd3);
    check("t6_phase_frozen", 32'(PHASE),     32'd0);
    check("t6_chg_frozen",   32'(PHASE_CHG), 32'd0);
`ifdef TLC_MON_CYCLE_COUNT_EN
    check("t6_cycles_frozen", 32'(CYCLES), 32'd3);
`endif
    hold(P_HG, 1);
    check("t6_dwell_resume", 32'(DWELL), 32'd4);
    check("t6_err_end",      32'(ERR),   32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
